debug_step_ctrl: RTL and testbench
==================================

DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

Interface
REQ-001 Parameter CMD_STEP, default 8'h04, UART command byte requesting one pipeline clock.
REQ-002 Parameter CMD_EXIT, default 8'h05, UART command byte ending step mode.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 is_start  input  1  one-cycle pulse from top FSM entering step mode.
REQ-006 i_rx_data  input  8  received UART byte, valid while is_rx_done=1.
REQ-007 is_rx_done  input  1  one-cycle strobe, new byte on i_rx_data.
REQ-008 is_send_done  input  1  one-cycle strobe, pipeline dump transmission finished.
REQ-009 is_stop_pipe  input  1  level, pipeline reached halt.
REQ-010 os_step  output  1  pipeline enable, one cycle per step.
REQ-011 os_start_send  output  1  one-cycle pulse starting a dump transmission.
REQ-012 os_done  output  1  one-cycle pulse, step mode finished.
REQ-013 o_clk_count  output  32  pipeline clocks executed since is_start.
REQ-014 o_busy  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, WAIT_CMD, STEP, SEND, WAIT_SEND, DONE; os_step/os_start_send/os_done/o_busy SHALL decode from the state register only (no input-to-output paths).
REQ-016 IDLE: is_start=1 -> WAIT_CMD next cycle; same edge clears o_clk_count to 0 and the stopped flag.
REQ-017 WAIT_CMD: is_rx_done=1 with CMD_STEP and stopped flag clear -> STEP; with CMD_STEP and stopped flag set -> SEND (no step, dump repeated).
REQ-018 WAIT_CMD: is_rx_done=1 with CMD_EXIT -> DONE; any other byte ignored, state held.
REQ-019 STEP: os_step=1 for exactly one cycle; o_clk_count increments by 1 on that edge, saturating at 32'hFFFF_FFFF; next state SEND.
REQ-020 SEND: os_start_send=1 for exactly one cycle; next state WAIT_SEND.
REQ-021 WAIT_SEND: is_send_done=1 -> DONE if stopped flag set, else WAIT_CMD; otherwise hold indefinitely (no timeout).
REQ-022 DONE: os_done=1 for exactly one cycle; next state IDLE; o_clk_count holds its value until next is_start.
REQ-023 Stopped flag SHALL set on any edge with is_stop_pipe=1 while o_busy=1, including the STEP cycle itself.
REQ-024 is_start outside IDLE, is_rx_done outside WAIT_CMD, is_send_done outside WAIT_SEND SHALL be ignored with no state effect.
REQ-025 Latency: CMD_STEP byte strobe to os_step = 1 cycle; os_step to os_start_send = 1 cycle.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, o_clk_count=0, stopped flag=0, all 1-bit outputs 0, including mid-step or mid-send.
REQ-027 Release of rst SHALL not generate any output pulse; first action requires a fresh is_start.

Structure
REQ-028 State encoding, CMD_STEP/CMD_EXIT defaults, and top-level command codes (01 load, 02 fast, 03 step) SHALL live in shared package debug_pkg, used also by the top debug FSM.
REQ-029 The saturating 32-bit counter with synchronous clear SHALL be sub-module step_counter; the rest is one FSM in debug_step_ctrl.

Verification
REQ-030 is_start, then 3x rx 8'h04 each followed by is_send_done -> 3 single-cycle os_step pulses, 3 os_start_send pulses, o_clk_count=3, o_busy=1.
REQ-031 After 2 steps, rx 8'h05 -> os_done one cycle later, then IDLE, o_clk_count=2 held, o_busy=0.
REQ-032 is_stop_pipe=1 during 4th STEP -> os_start_send, then on is_send_done os_done pulses without any CMD_EXIT; o_clk_count=4.
REQ-033 Stopped flag set in WAIT_CMD, rx 8'h04 -> os_start_send with no os_step; o_clk_count unchanged; rx 8'hAA -> no response.
REQ-034 rst=0 asserted while in WAIT_SEND with count 7 -> immediate IDLE, o_clk_count=0; later is_send_done pulse -> no output.
REQ-035 Preload counter to 32'hFFFF_FFFE, 3 steps -> o_clk_count stays 32'hFFFF_FFFF, no wrap to 0.

Source files
------------

// File: rtl/debug_pkg.sv
// debug_pkg: shared debug encodings for the step controller and the top debug FSM
package debug_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_CMD,
      S_STEP,
      S_SEND,
      S_WAIT_SEND,
      S_DONE
   } step_state_e;
   localparam logic [7:0] CMD_STEP_DEF = 8'h04;
   localparam logic [7:0] CMD_EXIT_DEF = 8'h05;
   typedef enum logic [7:0] {
      TOP_CMD_LOAD = 8'h01,
      TOP_CMD_FAST = 8'h02,
      TOP_CMD_STEP = 8'h03
   } top_cmd_e;
endpackage

// File: rtl/debug_step_ctrl_if.sv
// debug_step_ctrl_if: handshake bundle between the top debug FSM / UART and the step controller
interface debug_step_ctrl_if;
   logic        is_start;
   logic [7:0]  i_rx_data;
   logic        is_rx_done;
   logic        is_send_done;
   logic        is_stop_pipe;
   logic        os_step;
   logic        os_start_send;
   logic        os_done;
   logic [31:0] o_clk_count;
   logic        o_busy;
   modport master (
      output is_start, i_rx_data, is_rx_done, is_send_done, is_stop_pipe,
      input  os_step, os_start_send, os_done, o_clk_count, o_busy
   );
   modport slave (
      input  is_start, i_rx_data, is_rx_done, is_send_done, is_stop_pipe,
      output os_step, os_start_send, os_done, o_clk_count, o_busy
   );
endinterface

// File: rtl/debug_step_ctrl_step_counter.sv
// step_counter: saturating 32-bit pipeline clock counter with synchronous clear
module step_counter #(
   parameter logic [31:0] CNT_INIT = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        inc,
   output logic [31:0] count
);
   logic [31:0] count_d, count_q;
   // clear wins over increment; increment sticks at all-ones
   always_comb count_d = clr ? CNT_INIT : (inc && count_q != '1) ? count_q + 32'd1 : count_q;
   // count register, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst)
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   assign count = count_q;
endmodule

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: UART-driven single-step pipeline controller with dump handshake
module debug_step_ctrl
   import debug_pkg::*;
#(
   parameter logic [7:0]  CMD_STEP = CMD_STEP_DEF,
   parameter logic [7:0]  CMD_EXIT = CMD_EXIT_DEF,
   parameter logic [31:0] CNT_INIT = 32'h0
) (
   input  logic               clk,
   input  logic               rst,
   debug_step_ctrl_if.slave   bus
);
   step_state_e state_d, state_q;
   logic        stopped_d, stopped_q;
   logic        busy, start_ok;
   assign busy     = state_q != S_IDLE;
   assign start_ok = state_q == S_IDLE && bus.is_start;
   // next state; strobes arriving in the wrong state simply fall through to hold
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:      state_d = bus.is_start ? S_WAIT_CMD : S_IDLE;
         S_WAIT_CMD:  if (bus.is_rx_done)
                         state_d = bus.i_rx_data == CMD_STEP ? (stopped_q ? S_SEND : S_STEP) :
                                   bus.i_rx_data == CMD_EXIT ? S_DONE : S_WAIT_CMD;
         S_STEP:      state_d = S_SEND;
         S_SEND:      state_d = S_WAIT_SEND;
         S_WAIT_SEND: if (bus.is_send_done) state_d = stopped_q ? S_DONE : S_WAIT_CMD;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end
   // stopped flag: cleared on entry, latched whenever the pipe halts while active
   always_comb stopped_d = start_ok ? 1'b0 : (busy && bus.is_stop_pipe) ? 1'b1 : stopped_q;
   // state and stopped flag registers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q   <= S_IDLE;
         stopped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         stopped_q <= stopped_d;
      end
   step_counter #(.CNT_INIT(CNT_INIT)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_ok),
      .inc   (state_q == S_STEP),
      .count (bus.o_clk_count)
   );
   assign bus.os_step       = state_q == S_STEP;
   assign bus.os_start_send = state_q == S_SEND;
   assign bus.os_done       = state_q == S_DONE;
   assign bus.o_busy        = busy;
endmodule

// File: tb/tb_debug_step_ctrl.sv
// tb_debug_step_ctrl: directed checks of the step controller, plus a preloaded twin for saturation
module tb_debug_step_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   n_step = 0;
   int   n_send = 0;
   int   n_done = 0;
   int   s_step, s_send, s_done;
   debug_step_ctrl_if b1 ();
   debug_step_ctrl_if b2 ();
   always #5 clk = ~clk;
   debug_step_ctrl dut (.clk(clk), .rst(rst), .bus(b1));
   debug_step_ctrl #(.CNT_INIT(32'hFFFF_FFFE)) dut_sat (.clk(clk), .rst(rst), .bus(b2));
   assign b2.is_start     = b1.is_start;
   assign b2.i_rx_data    = b1.i_rx_data;
   assign b2.is_rx_done   = b1.is_rx_done;
   assign b2.is_send_done = b1.is_send_done;
   assign b2.is_stop_pipe = b1.is_stop_pipe;
   always @(negedge clk) begin
      if (b1.os_step)       n_step++;
      if (b1.os_start_send) n_send++;
      if (b1.os_done)       n_done++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic start();
      b1.is_start = 1'b1;
      tick();
      b1.is_start = 1'b0;
   endtask
   task automatic rx(input logic [7:0] d);
      b1.i_rx_data  = d;
      b1.is_rx_done = 1'b1;
      tick();
      b1.is_rx_done = 1'b0;
   endtask
   task automatic send_done();
      b1.is_send_done = 1'b1;
      tick();
      b1.is_send_done = 1'b0;
   endtask
   task automatic do_step(input int k);
      rx(8'h04);
      chk("step_pulse", 32'(b1.os_step), 32'd1);
      tick();
      chk("step_single", 32'(b1.os_step), 32'd0);
      chk("send_pulse", 32'(b1.os_start_send), 32'd1);
      chk("step_count", b1.o_clk_count, 32'(k));
      tick();
      send_done();
   endtask
   initial begin
      b1.is_start = 0; b1.i_rx_data = 0; b1.is_rx_done = 0; b1.is_send_done = 0; b1.is_stop_pipe = 0;
      repeat (2) tick();
      chk("rst_busy", 32'(b1.o_busy), 32'd0);
      chk("rst_count", b1.o_clk_count, 32'd0);
      rst = 1'b1;
      repeat (3) tick();
      chk("rel_pulses", 32'(n_step + n_send + n_done), 32'd0);
      // three steps, then exit
      start();
      chk("start_busy", 32'(b1.o_busy), 32'd1);
      for (int k = 1; k <= 3; k++) do_step(k);
      chk("a_nstep", 32'(n_step), 32'd3);
      chk("a_nsend", 32'(n_send), 32'd3);
      chk("a_count", b1.o_clk_count, 32'd3);
      chk("a_busy", 32'(b1.o_busy), 32'd1);
      chk("sat_count", b2.o_clk_count, 32'hFFFF_FFFF);
      rx(8'h05);
      chk("a_done", 32'(b1.os_done), 32'd1);
      tick();
      chk("a_idle", 32'(b1.o_busy), 32'd0);
      // two steps then exit, count held
      start();
      chk("b_clr", b1.o_clk_count, 32'd0);
      chk("sat_reload", b2.o_clk_count, 32'hFFFF_FFFE);
      for (int k = 1; k <= 2; k++) do_step(k);
      rx(8'h05);
      chk("b_done", 32'(b1.os_done), 32'd1);
      tick();
      chk("b_done_single", 32'(b1.os_done), 32'd0);
      chk("b_busy", 32'(b1.o_busy), 32'd0);
      repeat (2) tick();
      chk("b_hold", b1.o_clk_count, 32'd2);
      chk("sat_hold", b2.o_clk_count, 32'hFFFF_FFFF);
      // pipe halts during 4th step
      start();
      for (int k = 1; k <= 3; k++) do_step(k);
      s_done = n_done;
      rx(8'h04);
      b1.is_stop_pipe = 1'b1;
      tick();
      b1.is_stop_pipe = 1'b0;
      chk("c_send", 32'(b1.os_start_send), 32'd1);
      tick();
      send_done();
      chk("c_done", 32'(b1.os_done), 32'd1);
      chk("c_count", b1.o_clk_count, 32'd4);
      tick();
      chk("c_ndone", 32'(n_done - s_done), 32'd1);
      chk("c_idle", 32'(b1.o_busy), 32'd0);
      // stopped already in WAIT_CMD: unknown byte ignored, step repeats dump only
      start();
      b1.is_stop_pipe = 1'b1;
      tick();
      b1.is_stop_pipe = 1'b0;
      s_step = n_step;
      s_send = n_send;
      rx(8'hAA);
      send_done();
      repeat (2) tick();
      chk("d_aa_busy", 32'(b1.o_busy), 32'd1);
      chk("d_aa_quiet", 32'(n_step - s_step + n_send - s_send + n_done - s_done - 1), 32'd0);
      rx(8'h04);
      chk("d_nostep", 32'(b1.os_step), 32'd0);
      chk("d_send", 32'(b1.os_start_send), 32'd1);
      chk("d_count", b1.o_clk_count, 32'd0);
      tick();
      send_done();
      chk("d_done", 32'(b1.os_done), 32'd1);
      tick();
      chk("d_nstep", 32'(n_step - s_step), 32'd0);
      // reset in the middle of WAIT_SEND
      start();
      for (int k = 1; k <= 6; k++) do_step(k);
      rx(8'h04);
      repeat (2) tick();
      chk("e_count7", b1.o_clk_count, 32'd7);
      chk("e_busy", 32'(b1.o_busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("e_async_busy", 32'(b1.o_busy), 32'd0);
      chk("e_async_count", b1.o_clk_count, 32'd0);
      tick();
      rst = 1'b1;
      s_step = n_step;
      s_send = n_send;
      s_done = n_done;
      send_done();
      rx(8'h04);
      repeat (3) tick();
      chk("e_quiet", 32'(n_step - s_step + n_send - s_send + n_done - s_done), 32'd0);
      chk("e_idle", 32'(b1.o_busy), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
